// File: rtl/obi_spi_flash_rom.sv
// -----------------------------------------------------------------------------
// obi_spi_flash_rom
//
// OBI subordinate serving read-only words from an external SPI NOR flash.
// Every in-range OBI read becomes one READ (0x03) frame in SPI mode 0:
// 8-bit command, FlashAddrBytes address bytes, then 32 read bits.
// Writes and out-of-window reads are answered with err=1 and no SPI traffic.
//
// Optional feature macro: OBI_SPI_ROM_WORD_BUFFER_EN
//   When defined, a single-entry word buffer (valid, tag, data) is added.
//   A read that hits the buffer is answered in one cycle from the HIT state
//   without touching the SPI pins. Misses refill it when the SPI read ends.
//
// Ports
//   clk_i       in   system clock (the only clock)
//   rst_i       in   asynchronous active-high reset
//   obi_req_i   in   OBI request  (a.addr, a.we, a.aid, req; rest ignored)
//   obi_rsp_o   out  OBI response (gnt, rvalid, r.rdata, r.rid, r.err)
//   spi_cs_n_o  out  flash chip select, active low, registered
//   spi_sck_o   out  serial clock, idles low, registered
//   spi_mosi_o  out  command/address bits, registered
//   spi_miso_i  in   flash data; timed by SCK, sampled without synchroniser
// -----------------------------------------------------------------------------

package obi_spi_flash_rom_pkg;

  localparam int unsigned IdWidth = 4;

  typedef struct packed {
    int unsigned DataWidth;
    int unsigned AddrWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    DataWidth: 32,
    AddrWidth: 32,
    IdWidth:   IdWidth
  };

  typedef struct packed {
    logic [31:0]        addr;
    logic               we;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic [IdWidth-1:0] aid;
    logic               a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [31:0]        rdata;
    logic [IdWidth-1:0] rid;
    logic               err;
    logic               r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } obi_rsp_t;

endpackage

module obi_spi_flash_rom #(
  parameter obi_spi_flash_rom_pkg::obi_cfg_t ObiCfg = obi_spi_flash_rom_pkg::ObiDefaultConfig,
  parameter type obi_req_t = obi_spi_flash_rom_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_spi_flash_rom_pkg::obi_rsp_t,
  parameter logic [31:0] BaseAddr       = 32'h1000_0000,
  parameter logic [31:0] Size           = 32'h0010_0000,
  parameter int unsigned ClkDiv         = 1,
  parameter int unsigned FlashAddrBytes = 3
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output logic     spi_cs_n_o,
  output logic     spi_sck_o,
  output logic     spi_mosi_o,
  input  logic     spi_miso_i
);

  localparam int unsigned AddrBits  = 8 * FlashAddrBytes;
  localparam int unsigned FrameBits = 8 * (1 + FlashAddrBytes) + 32;
  localparam int unsigned CntW      = $clog2(FrameBits);
  localparam int unsigned DivW      = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int unsigned IdW       = ObiCfg.IdWidth;

  localparam logic [CntW-1:0] LastBit = CntW'(FrameBits - 1);
  localparam logic [DivW-1:0] LastDiv = DivW'(ClkDiv - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_DONE  = 3'd2;
  localparam logic [2:0] ST_ERR   = 3'd3;
`ifdef OBI_SPI_ROM_WORD_BUFFER_EN
  localparam logic [2:0] ST_HIT   = 3'd4;
`endif

  logic [2:0]           state_q;
  logic [FrameBits-1:0] frame_q;
  logic [CntW-1:0]      bit_q;
  logic [DivW-1:0]      div_q;
  logic [31:0]          rx_q;
  logic [IdW-1:0]       aid_q;
  logic                 cs_n_q;
  logic                 sck_q;
  logic                 mosi_q;

  // Request decode
  logic                 in_range;
  logic [31:0]          offset;
  logic [AddrBits-1:0]  fa;
  logic [FrameBits-1:0] frame_init;
  logic [31:0]          rx_word;
  logic                 gnt;

  // Handshake: a request is granted in the same cycle req is seen while the
  // FSM is IDLE (and reset is released); the grant cycle is the address
  // phase. Exactly one response follows with rvalid high for a single cycle.
  // rready is ignored because the manager always accepts the response.
  assign gnt = obi_req_i.req && (state_q == ST_IDLE) && !rst_i;

  assign in_range = (obi_req_i.a.addr >= BaseAddr) &&
                    ({1'b0, obi_req_i.a.addr} < ({1'b0, BaseAddr} + {1'b0, Size}));
  assign offset   = obi_req_i.a.addr - BaseAddr;
  // Word-aligned flash byte address; the window size is a power of two.
  assign fa       = AddrBits'(offset & (Size - 32'd1)) & ~AddrBits'(32'd3);

  assign frame_init = {8'h03, fa, 32'h0000_0000};

  // The first byte shifted in lands in rx_q[31:24]; flash byte order is
  // little-endian on the bus, so swap bytes.
  assign rx_word = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

`ifdef OBI_SPI_ROM_WORD_BUFFER_EN
  logic                buf_valid_q;
  logic [AddrBits-1:0] buf_tag_q;
  logic [31:0]         buf_data_q;
  logic [AddrBits-1:0] addr_q;
  logic                buf_hit;

  assign buf_hit = buf_valid_q && (buf_tag_q == fa);
`endif

  // Main FSM and SPI shifter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      rx_q    <= '0;
      aid_q   <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt) begin
            aid_q <= obi_req_i.a.aid;
            if (obi_req_i.a.we || !in_range) begin
              state_q <= ST_ERR;
            end
`ifdef OBI_SPI_ROM_WORD_BUFFER_EN
            else if (buf_hit) begin
              state_q <= ST_HIT;
            end
`endif
            else begin
              state_q <= ST_SHIFT;
              frame_q <= frame_init;
              mosi_q  <= frame_init[FrameBits-1];
              cs_n_q  <= 1'b0;
              sck_q   <= 1'b0;
              bit_q   <= '0;
              div_q   <= '0;
            end
          end
        end

        ST_SHIFT: begin
          if (div_q == LastDiv) begin
            div_q <= '0;
            if (!sck_q) begin
              // Rising SCK: the flash has held MISO stable since the fall.
              sck_q <= 1'b1;
              rx_q  <= {rx_q[30:0], spi_miso_i};
            end else begin
              sck_q <= 1'b0;
              if (bit_q == LastBit) begin
                state_q <= ST_DONE;
                cs_n_q  <= 1'b1;
                mosi_q  <= 1'b0;
              end else begin
                bit_q   <= bit_q + 1'b1;
                frame_q <= frame_q << 1;
                mosi_q  <= frame_q[FrameBits-2];
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        ST_DONE: state_q <= ST_IDLE;
        ST_ERR:  state_q <= ST_IDLE;
`ifdef OBI_SPI_ROM_WORD_BUFFER_EN
        ST_HIT:  state_q <= ST_IDLE;
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef OBI_SPI_ROM_WORD_BUFFER_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      addr_q      <= '0;
    end else begin
      if (gnt) begin
        addr_q <= fa;
      end
      if (state_q == ST_DONE) begin
        buf_valid_q <= 1'b1;
        buf_tag_q   <= addr_q;
        buf_data_q  <= rx_word;
      end
    end
  end
`endif

  // Response channel: rvalid only in the single-cycle response states.
  always_comb begin
    obi_rsp_o     = '0;
    obi_rsp_o.gnt = gnt;
    case (state_q)
      ST_DONE: begin
        obi_rsp_o.rvalid  = 1'b1;
        obi_rsp_o.r.rdata = rx_word;
        obi_rsp_o.r.rid   = aid_q;
      end
      ST_ERR: begin
        obi_rsp_o.rvalid = 1'b1;
        obi_rsp_o.r.err  = 1'b1;
        obi_rsp_o.r.rid  = aid_q;
      end
`ifdef OBI_SPI_ROM_WORD_BUFFER_EN
      ST_HIT: begin
        obi_rsp_o.rvalid  = 1'b1;
        obi_rsp_o.r.rdata = buf_data_q;
        obi_rsp_o.r.rid   = aid_q;
      end
`endif
      default: ;
    endcase
  end

  assign spi_cs_n_o = cs_n_q;
  assign spi_sck_o  = sck_q;
  assign spi_mosi_o = mosi_q;

  // Request fields this read-only subordinate never looks at.
  logic unused_req;
  assign unused_req = ^{obi_req_i.a.be, obi_req_i.a.wdata,
                        obi_req_i.a.a_optional, obi_req_i.rready};

endmodule
